// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor
// Sequences one test run of an external CPU-like DUT. It holds the DUT in
// reset for RESET_CYCLES clocks, releases it, then watches dut_out until the
// bus has been unchanged for HALT_STABLE consecutive RUN cycles (a halt) or
// until TIMEOUT RUN cycles have elapsed. On a halt the final bus value is
// compared with expect_val.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle run request, accepted in IDLE and DONE only
//   dut_out      observed DUT output bus [NUM_CH]
//   expect_val   expected final value of dut_out [NUM_CH]
//   dut_rst_n    registered active-low reset to the DUT
//   running      high in RESET_HOLD and RUN
//   done         high in DONE
//   pass         halt result, meaningful while done is high
//   timeout      run aborted on the cycle limit, meaningful while done is high
//   cycle_count  RUN cycles elapsed [CNT_W], saturating
//
// state      | meaning
// IDLE       | DUT held in reset, waiting for start
// RESET_HOLD | DUT held in reset for RESET_CYCLES clocks
// RUN        | DUT released, watching dut_out for halt or timeout
// DONE       | result frozen, DUT left running, start begins a new run

module cpu_run_monitor #(
  parameter int NUM_CH       = 1,
  parameter int RESET_CYCLES = 5,
  parameter int HALT_STABLE  = 8,
  parameter int TIMEOUT      = 1000,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] dut_out,
  input  logic [NUM_CH-1:0] expect_val,
  output logic              dut_rst_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [7:0]       HOLD_LAST    = 8'(RESET_CYCLES - 1);
  // Halt fires when the counter is about to reach HALT_STABLE-1, i.e. the
  // bus has held one value for HALT_STABLE RUN cycles including this one.
  localparam logic [7:0]       HALT_PRE     = 8'(HALT_STABLE - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t            state;
  logic [7:0]        hold_cnt;
  logic [7:0]        stable_cnt;
  logic [NUM_CH-1:0] prev_out;

  logic same;
  logic first_cycle;
  logic halt_hit;
  logic timeout_hit;

  assign same        = (dut_out == prev_out);
  // cycle_count is cleared on start and saturates, so zero marks only the
  // first RUN cycle; prev_out there still holds a stale value.
  assign first_cycle = (cycle_count == '0);
  assign halt_hit    = same && !first_cycle && (stable_cnt == HALT_PRE);
  assign timeout_hit = (cycle_count == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      stable_cnt  <= '0;
      prev_out    <= '0;
      dut_rst_n   <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RESET_HOLD;
            hold_cnt    <= HOLD_LAST;
            stable_cnt  <= '0;
            cycle_count <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            dut_rst_n   <= 1'b0;
            running     <= 1'b1;
            done        <= 1'b0;
          end
        end

        RESET_HOLD: begin
          if (hold_cnt == '0) begin
            state     <= RUN;
            dut_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        RUN: begin
          prev_out <= dut_out;
          // Halt is checked first so it wins a tie with the cycle limit.
          if (halt_hit) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= (dut_out == expect_val);
            timeout <= 1'b0;
          end else if (timeout_hit) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            if (cycle_count != CNT_MAX) begin
              cycle_count <= cycle_count + CNT_W'(1);
            end
            if (first_cycle || !same) begin
              stable_cnt <= '0;
            end else begin
              stable_cnt <= stable_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor
// Drives cpu_run_monitor through directed and random runs. The reference
// model tracks how long dut_out has held one value during RUN and which RUN
// cycle is current, and derives done/pass/timeout/cycle_count from that.

module tb_cpu_run_monitor;

  localparam int NUM_CH = 4;
  localparam int RC     = 5;
  localparam int HS     = 8;
  localparam int TO     = 50;
  localparam int CW     = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NUM_CH-1:0] dut_out;
  logic [NUM_CH-1:0] expect_val;
  logic              dut_rst_n;
  logic              running;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [CW-1:0]     cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .NUM_CH      (NUM_CH),
    .RESET_CYCLES(RC),
    .HALT_STABLE (HS),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dut_out    (dut_out),
    .expect_val (expect_val),
    .dut_rst_n  (dut_rst_n),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rst_n"},   32'(dut_rst_n),   0);
    check_val({tag, "_running"}, 32'(running),     0);
    check_val({tag, "_done"},    32'(done),        0);
    check_val({tag, "_pass"},    32'(pass),        0);
    check_val({tag, "_timeout"}, 32'(timeout),     0);
    check_val({tag, "_count"},   32'(cycle_count), 0);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_running", 32'(running),   0);
      check_val("idle_rst_n",   32'(dut_rst_n), 0);
      check_val("idle_done",    32'(done),      0);
    end
  endtask

  // mode 0: toggle 1,0,.. for 20 cycles then hold 1
  // mode 1: toggle every cycle
  // mode 2: toggle for 42 cycles then hold 1 (halt lands on the limit cycle)
  // mode 3: random, mostly holding the previous value
  // mode 4: constant cval
  function automatic logic [NUM_CH-1:0] gen(input int mode, input int k,
                                            input logic [NUM_CH-1:0] prev,
                                            input logic [NUM_CH-1:0] cval);
    logic [NUM_CH-1:0] v;
    case (mode)
      0:       v = (k <= 20) ? NUM_CH'(k % 2) : NUM_CH'(1);
      1:       v = NUM_CH'(k % 2);
      2:       v = (k <= 42) ? NUM_CH'(k % 2) : NUM_CH'(1);
      3:       v = ($urandom_range(0, 3) == 0 || k == 1) ? NUM_CH'($urandom_range(0, 3)) : prev;
      default: v = cval;
    endcase
    return v;
  endfunction

  task automatic do_run(input int mode, input logic [NUM_CH-1:0] exp_v,
                        input logic [NUM_CH-1:0] cval, input int reset_at,
                        input int ign_at);
    logic [NUM_CH-1:0] v;
    logic [NUM_CH-1:0] prev;
    int  run_len;
    bit  halt;
    bit  tmo;
    int  exp_cnt;
    bit  exp_pass;
    bit  exp_to;

    prev    = '0;
    run_len = 0;
    @(negedge clk);
    start      = 1'b1;
    expect_val = exp_v;
    @(negedge clk);
    start = 1'b0;
    check_val("start_running", 32'(running),     1);
    check_val("start_done",    32'(done),        0);
    check_val("start_pass",    32'(pass),        0);
    check_val("start_timeout", 32'(timeout),     0);
    check_val("start_count",   32'(cycle_count), 0);
    check_val("start_rst_n",   32'(dut_rst_n),   0);
    for (int i = 2; i <= RC; i++) begin
      @(negedge clk);
      check_val("hold_rst_n", 32'(dut_rst_n), 0);
    end

    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) check_val("run_rst_n_rise", 32'(dut_rst_n), 1);
      check_val("run_running", 32'(running),     1);
      check_val("run_done",    32'(done),        0);
      check_val("run_count",   32'(cycle_count), 32'(k - 1));

      if (k == reset_at) begin
        reset = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        check_all_zero("midrun_reset_held");
        reset = 1'b1;
        check_idle(4);
        return;
      end

      if (k == ign_at) start = 1'b1;
      v       = gen(mode, k, prev, cval);
      dut_out = v;
      if (k == 1 || v != prev) run_len = 1;
      else run_len++;
      prev = v;
      halt = (run_len == HS);
      tmo  = (k == TO);
      if (halt || tmo) begin
        exp_pass = halt && (v == exp_v);
        exp_to   = !halt;
        exp_cnt  = k - 1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
          check_val("done_done",    32'(done),        1);
          check_val("done_running", 32'(running),     0);
          check_val("done_rst_n",   32'(dut_rst_n),   1);
          check_val("done_pass",    32'(pass),        32'(exp_pass));
          check_val("done_timeout", 32'(timeout),     32'(exp_to));
          check_val("done_count",   32'(cycle_count), 32'(exp_cnt));
          dut_out = NUM_CH'($urandom_range(0, 15));
          @(negedge clk);
        end
        return;
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    dut_out    = '0;
    expect_val = '0;
    #1;
    check_all_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_idle(3);

    // nominal halt with a correct result
    do_run(0, 4'h1, 4'h0, 0, 0);
    check_val("nominal_count_27", 32'(cycle_count), 27);
    check_val("nominal_pass",     32'(pass),        1);

    // same stimulus, wrong expected value
    do_run(0, 4'h0, 4'h0, 0, 0);
    check_val("wrong_pass", 32'(pass), 0);

    // toggling bus never halts
    do_run(1, 4'h1, 4'h0, 0, 0);
    check_val("timeout_count_49", 32'(cycle_count), 49);
    check_val("timeout_flag",     32'(timeout),     1);

    // halt and limit reached on the same cycle
    do_run(2, 4'h1, 4'h0, 0, 0);
    check_val("tie_timeout", 32'(timeout), 0);
    check_val("tie_pass",    32'(pass),    1);

    // abort at RUN cycle 10, then a clean nominal run
    do_run(0, 4'h1, 4'h0, 10, 0);
    do_run(0, 4'h1, 4'h0, 0, 0);
    check_val("after_reset_count_27", 32'(cycle_count), 27);

    // start during RUN is ignored; wide constant value
    do_run(4, 4'hA, 4'hA, 0, 5);
    check_val("ignore_count", 32'(cycle_count), 7);
    check_val("ignore_pass",  32'(pass),        1);

    for (int r = 0; r < 25; r++) begin
      do_run(3, NUM_CH'($urandom_range(0, 3)), 4'h0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0,
             int'($urandom_range(0, 20)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
